ram_arbiter: RTL and testbench

//   Shares one ram instance (1 read + 1 write address, registered 1-cycle read)

---
 rtl/ram_arbiter.sv | 144 ++++++++++++++
 tb/tb_ram_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares one single-port-read / single-port-write ram with a
// registered 1-cycle read between an instruction-fetch port (0) and a
// data load/store port (1). Round-robin grant, one access in flight.
module ram_arbiter #(
    parameter int data_width = 32,
    parameter int addr_width = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic                  req0_write,
    input  logic [addr_width-1:0] req0_addr,
    input  logic [data_width-1:0] req0_wdata,
    output logic                  req0_ready,
    output logic                  rsp0_valid,
    output logic [data_width-1:0] rsp0_rdata,
    input  logic                  req1_valid,
    input  logic                  req1_write,
    input  logic [addr_width-1:0] req1_addr,
    input  logic [data_width-1:0] req1_wdata,
    output logic                  req1_ready,
    output logic                  rsp1_valid,
    output logic [data_width-1:0] rsp1_rdata,
    output logic [addr_width-1:0] ram_read_address,
    output logic [addr_width-1:0] ram_write_address,
    output logic                  ram_write,
    output logic [data_width-1:0] ram_din,
    input  logic [data_width-1:0] ram_dout
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RD_WAIT = 2'd1;
    localparam logic [1:0] RD_RESP = 2'd2;

    // Per-port views of the request ports so the datapath can be indexed.
    logic [1:0]            req_valid;
    logic [1:0]            req_write;
    logic [addr_width-1:0] req_addr  [2];
    logic [data_width-1:0] req_wdata [2];

    assign req_valid    = {req1_valid, req0_valid};
    assign req_write    = {req1_write, req0_write};
    assign req_addr[0]  = req0_addr;
    assign req_addr[1]  = req1_addr;
    assign req_wdata[0] = req0_wdata;
    assign req_wdata[1] = req1_wdata;

    logic [1:0] state_reg, state_next;
    logic       ptr_reg, ptr_next;
    logic       owner_reg, owner_next;

    logic       grant_any;
    logic       grant_port;
    logic       sel_port;
    logic [1:0] ready;

    logic [1:0]            rsp_valid_reg;
    logic [data_width-1:0] rsp_rdata_reg [2];

    // Grant: only in IDLE and never while reset is high; a lone requester
    // wins outright, a tie goes to the port the priority pointer names.
    always_comb begin
        grant_any  = (state_reg == IDLE) && !reset && (req_valid != 2'b00);
        grant_port = (req_valid == 2'b11) ? ptr_reg : req_valid[1];
        sel_port   = grant_any ? grant_port : ptr_reg;
        ready      = 2'b00;
        if (grant_any) begin
            ready = grant_port ? 2'b10 : 2'b01;
        end
    end

    assign req0_ready = ready[0];
    assign req1_ready = ready[1];

    // The ram always sees the selected port's fields; only the write strobe
    // depends on an actual accept, so idle cycles never disturb memory.
    assign ram_read_address  = req_addr[sel_port];
    assign ram_write_address = req_addr[sel_port];
    assign ram_din           = req_wdata[sel_port];
    assign ram_write         = grant_any && req_write[grant_port];

    // Next-state logic: writes complete in the accept cycle, reads walk
    // through RD_WAIT (ram output valid) and RD_RESP (response pulse).
    always_comb begin
        state_next = state_reg;
        owner_next = owner_reg;
        ptr_next   = ptr_reg;
        if (grant_any) begin
            ptr_next = ~grant_port;
        end
        case (state_reg)
            IDLE: begin
                if (grant_any && !req_write[grant_port]) begin
                    state_next = RD_WAIT;
                    owner_next = grant_port;
                end
            end
            RD_WAIT: state_next = RD_RESP;
            RD_RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Control registers; reset abandons any read in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            ptr_reg   <= 1'b0;
            owner_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            owner_reg <= owner_next;
        end
    end

    // Response registers per port: capture ram_dout in RD_WAIT so data and
    // the valid pulse appear together during RD_RESP; data holds afterwards.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rsp
            logic capture;
            assign capture = (state_reg == RD_WAIT) && (owner_reg == 1'(gi));

            // Valid is a one-cycle pulse; rdata only changes on capture.
            always_ff @(posedge clk) begin
                if (reset) begin
                    rsp_valid_reg[gi] <= 1'b0;
                    rsp_rdata_reg[gi] <= '0;
                end else begin
                    rsp_valid_reg[gi] <= capture;
                    if (capture) begin
                        rsp_rdata_reg[gi] <= ram_dout;
                    end
                end
            end
        end
    endgenerate

    assign rsp0_valid = rsp_valid_reg[0];
    assign rsp1_valid = rsp_valid_reg[1];
    assign rsp0_rdata = rsp_rdata_reg[0];
    assign rsp1_rdata = rsp_rdata_reg[1];

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: drives both requester ports from per-port scripts, models
// the ram behaviourally, and checks every cycle against a transaction-level
// reference (grant pointer, busy window, expected memory, response queue).
module tb_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_write;
    logic [1:0][3:0]  req_addr;
    logic [1:0][31:0] req_wdata;
    logic [1:0]  req_ready;
    logic [1:0]  rsp_valid;
    logic [31:0] rsp_rdata [2];
    logic [3:0]  ram_read_address;
    logic [3:0]  ram_write_address;
    logic        ram_write;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    always #5 clk = ~clk;

    ram_arbiter #(.data_width(32), .addr_width(4)) dut (
        .clk               (clk),
        .reset             (reset),
        .req0_valid        (req_valid[0]),
        .req0_write        (req_write[0]),
        .req0_addr         (req_addr[0]),
        .req0_wdata        (req_wdata[0]),
        .req0_ready        (req_ready[0]),
        .rsp0_valid        (rsp_valid[0]),
        .rsp0_rdata        (rsp_rdata[0]),
        .req1_valid        (req_valid[1]),
        .req1_write        (req_write[1]),
        .req1_addr         (req_addr[1]),
        .req1_wdata        (req_wdata[1]),
        .req1_ready        (req_ready[1]),
        .rsp1_valid        (rsp_valid[1]),
        .rsp1_rdata        (rsp_rdata[1]),
        .ram_read_address  (ram_read_address),
        .ram_write_address (ram_write_address),
        .ram_write         (ram_write),
        .ram_din           (ram_din),
        .ram_dout          (ram_dout)
    );

    // ---------------- ram model (registered read) ----------------
    logic        ram_load;
    logic [31:0] mem [16];

    function automatic logic [31:0] init_word(input int i);
        return (i == 3) ? 32'h0000_00A5 : (32'h1000_0000 | 32'(i));
    endfunction

    always @(posedge clk) begin
        if (ram_load) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_word(i);
        end else begin
            if (ram_write) mem[ram_write_address] <= ram_din;
            ram_dout <= mem[ram_read_address];
        end
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // ---------------- reference model + scoreboard ----------------
    typedef struct {
        logic        port;
        logic [31:0] data;
        int          due;
    } rsp_t;

    rsp_t        sb [$];
    logic [31:0] ref_mem [16];
    logic [31:0] exp_rdata [2];
    logic        exp_ptr;
    int          exp_busy;
    logic        gp, acc, sel;
    logic [1:0]  e_rdy;

    always @(negedge clk) begin
        if (reset) begin
            check("ready_in_reset", {62'd0, req_ready}, 64'd0);
            check("write_in_reset", {63'd0, ram_write}, 64'd0);
            if (ram_load) begin
                for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
            end
            sb.delete();
            exp_busy     = 0;
            exp_ptr      = 1'b0;
            exp_rdata[0] = 32'd0;
            exp_rdata[1] = 32'd0;
        end else begin
            gp    = (req_valid == 2'b11) ? exp_ptr : req_valid[1];
            acc   = (exp_busy == 0) && (req_valid != 2'b00);
            e_rdy = acc ? (gp ? 2'b10 : 2'b01) : 2'b00;
            sel   = acc ? gp : exp_ptr;
            check("ready", {62'd0, req_ready}, {62'd0, e_rdy});
            check("ram_write", {63'd0, ram_write}, {63'd0, acc && req_write[gp]});
            check("ram_rd_addr", {60'd0, ram_read_address}, {60'd0, req_addr[sel]});
            check("ram_wr_addr", {60'd0, ram_write_address}, {60'd0, req_addr[sel]});
            check("ram_din", {32'd0, ram_din}, {32'd0, req_wdata[sel]});

            for (int p = 0; p < 2; p++) begin
                logic due_now;
                due_now = (sb.size() > 0) && (sb[0].due == cyc) && (sb[0].port == 1'(p));
                check($sformatf("rsp%0d_valid", p), {63'd0, rsp_valid[p]}, {63'd0, due_now});
                if (due_now) begin
                    exp_rdata[p] = sb[0].data;
                    $display("cyc %0d: rsp port%0d data %08h", cyc, p, rsp_rdata[p]);
                    void'(sb.pop_front());
                end
                check($sformatf("rsp%0d_rdata", p), {32'd0, rsp_rdata[p]}, {32'd0, exp_rdata[p]});
            end
            if (sb.size() > 0 && sb[0].due < cyc) begin
                check("rsp_due_cycle", 64'(cyc), 64'(sb[0].due));
                void'(sb.pop_front());
            end

            if (acc) begin
                exp_ptr = ~gp;
                if (req_write[gp]) begin
                    ref_mem[req_addr[gp]] = req_wdata[gp];
                    $display("cyc %0d: accept port%0d WR addr %0d data %08h",
                             cyc, gp, req_addr[gp], req_wdata[gp]);
                end else begin
                    sb.push_back('{port: gp, data: ref_mem[req_addr[gp]], due: cyc + 2});
                    exp_busy = 2;
                    $display("cyc %0d: accept port%0d RD addr %0d", cyc, gp, req_addr[gp]);
                end
            end else if (exp_busy > 0) begin
                exp_busy--;
            end
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic        wr;
        logic [3:0]  addr;
        logic [31:0] data;
    } req_t;

    req_t       scr0 [$];
    req_t       scr1 [$];
    logic [1:0] took;

    function automatic req_t mk(input logic wr, input int addr, input logic [31:0] data);
        req_t r;
        r.wr   = wr;
        r.addr = 4'(addr);
        r.data = data;
        return r;
    endfunction

    // Plays both scripts, holding each request until accepted, until the
    // scripts and the response queue are empty or the budget runs out.
    task automatic run(input int budget);
        int   n;
        req_t cur;
        n = 0;
        forever begin
            @(posedge clk); #1;
            for (int p = 0; p < 2; p++) begin
                if (!req_valid[p] || took[p]) begin
                    if ((p == 0 && scr0.size() > 0) || (p == 1 && scr1.size() > 0)) begin
                        cur = (p == 0) ? scr0.pop_front() : scr1.pop_front();
                        req_valid[p] = 1'b1;
                        req_write[p] = cur.wr;
                        req_addr[p]  = cur.addr;
                        req_wdata[p] = cur.data;
                    end else begin
                        req_valid[p] = 1'b0;
                    end
                end
            end
            @(negedge clk);
            took = req_valid & req_ready;
            #1;
            n++;
            if (scr0.size() == 0 && scr1.size() == 0 &&
                (req_valid & ~took) == 2'b00 && sb.size() == 0) break;
            if (n > budget) begin
                check("run_timeout", 64'(n), 64'(budget));
                break;
            end
        end
        @(posedge clk); #1;
        req_valid = 2'b00;
        took      = 2'b00;
    endtask

    initial begin
        ram_load  = 1'b1;
        reset     = 1'b1;
        req_valid = 2'b00;
        req_write = 2'b00;
        req_addr  = '0;
        req_wdata = '0;
        took      = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        ram_load = 1'b0;
        reset    = 1'b0;

        // Single port-0 read of the preloaded word.
        scr0.push_back(mk(1'b0, 3, 32'd0));
        run(50);

        // Port-1 write then read-back of the same address next cycle.
        scr1.push_back(mk(1'b1, 5, 32'hDEAD_BEEF));
        scr1.push_back(mk(1'b0, 5, 32'd0));
        run(50);

        // Competing reads: grants must alternate.
        for (int i = 0; i < 4; i++) begin
            scr0.push_back(mk(1'b0, i, 32'd0));
            scr1.push_back(mk(1'b0, 8 + i, 32'd0));
        end
        run(100);

        // Competing writes every cycle, then read everything back.
        for (int i = 0; i < 4; i++) begin
            scr0.push_back(mk(1'b1, 12 + i, 32'hA000_0000 | 32'(i)));
            scr1.push_back(mk(1'b1, 8 + i, 32'hB000_0000 | 32'(i)));
        end
        run(100);
        for (int i = 0; i < 4; i++) begin
            scr0.push_back(mk(1'b0, 12 + i, 32'd0));
            scr1.push_back(mk(1'b0, 8 + i, 32'd0));
        end
        run(100);

        // Reset during RD_WAIT: response dropped, pointer back to port 0.
        @(posedge clk); #1;
        req_valid = 2'b01;
        req_write = 2'b00;
        req_addr[0] = 4'd7;
        @(negedge clk);
        @(posedge clk); #1;
        req_valid = 2'b00;
        reset     = 1'b1;
        @(posedge clk); #1;
        reset       = 1'b0;
        req_valid   = 2'b11;
        req_write   = 2'b00;
        req_addr[0] = 4'd5;
        req_addr[1] = 4'd9;
        @(negedge clk);
        check("regrant_after_reset", {62'd0, req_ready}, 64'd1);
        took = req_valid & req_ready;
        run(50);

        // Memory survived the reset: port 0 reads 7 and the earlier write at 5.
        scr0.push_back(mk(1'b0, 7, 32'd0));
        scr0.push_back(mk(1'b0, 5, 32'd0));
        run(50);

        repeat (4) @(negedge clk);
        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
